alien_march_ctrl: RTL

//  Sequences the alien formation. Owns the formation origin (top-left of col0/row0) and march direction.

---
 rtl/alien_march_if.sv | 29 ++
 rtl/alien_march_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alien_march_if.sv
// Handshake bundle between frame timing / wave control and the alien march sequencer.
//   master : drives frame_tick, start, pause, col_alive; observes formation state
//   slave  : the sequencer; consumes controls, returns form_x/form_y/dir, pulses and status flags
interface alien_march_if #(
  parameter int NUM_COLS = 6
);
  logic                frame_tick;
  logic                start;
  logic                pause;
  logic [NUM_COLS-1:0] col_alive;
  logic [10:0]         form_x;
  logic [9:0]          form_y;
  logic                dir;
  logic                step_pulse;
  logic                drop_pulse;
  logic                marching;
  logic                invaded;
  logic                wave_clear;

  modport master (
    output frame_tick, start, pause, col_alive,
    input  form_x, form_y, dir, step_pulse, drop_pulse, marching, invaded, wave_clear
  );

  modport slave (
    input  frame_tick, start, pause, col_alive,
    output form_x, form_y, dir, step_pulse, drop_pulse, marching, invaded, wave_clear
  );
endinterface

// File: rtl/alien_march_ctrl.sv
// Alien formation march sequencer. Owns the formation origin (top-left of col0/row0)
// and march direction, steps sideways on frame ticks at a rate set by the number of
// live columns, drops and reverses at the playfield edges, and flags invasion / wave clear.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus (slave)     frame_tick, start, pause, col_alive in;
//                   form_x, form_y, dir, step_pulse, drop_pulse, marching, invaded, wave_clear out
// All outputs are registered.
module alien_march_ctrl #(
  parameter int HRES        = 1280,
  parameter int NUM_COLS    = 6,
  parameter int NUM_ROWS    = 10,
  parameter int ENEMY_W     = 32,
  parameter int ENEMY_H     = 28,
  parameter int SPACING_X   = 50,
  parameter int SPACING_Y   = 16,
  parameter int ENEMY_SPEED = 1,
  parameter int DROP        = 32,
  parameter int HSTART      = 419,
  parameter int VSTART      = 108,
  parameter int V_LIMIT     = 700
) (
  input logic         clk,
  input logic         rst,
  alien_march_if.slave bus
);
  localparam int PITCH  = ENEMY_W + SPACING_X;
  localparam int FORM_H = NUM_ROWS * ENEMY_H + (NUM_ROWS - 1) * SPACING_Y;
  localparam int PW     = $clog2(NUM_COLS + 1);
  localparam int CW     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MARCH, S_INVADED, S_CLEAR} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] tick_cnt, tick_cnt_nxt;
  logic [PW-1:0] period;
  logic [PW:0]   cnt_inc;
  logic [CW-1:0] col_lo, col_hi;
  logic [11:0]   left_edge, right_edge;
  logic [10:0]   bottom_nxt;
  logic          hit_edge, invade, move;

  logic [10:0] form_x, form_x_nxt;
  logic [9:0]  form_y, form_y_nxt;
  logic        dir, dir_nxt;
  logic        step_pulse, step_nxt;
  logic        drop_pulse, drop_nxt;
  logic        marching, marching_nxt;
  logic        invaded, invaded_nxt;
  logic        wave_clear, clear_nxt;

  function automatic logic [PW-1:0] popcount(input logic [NUM_COLS-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLS; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  function automatic logic [CW-1:0] lowest_set(input logic [NUM_COLS-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) if (v[i]) idx = CW'(i);
    return idx;
  endfunction

  function automatic logic [CW-1:0] highest_set(input logic [NUM_COLS-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS; i++) if (v[i]) idx = CW'(i);
    return idx;
  endfunction

  // Formation geometry from the live-column mask
  assign period     = popcount(bus.col_alive);
  assign cnt_inc    = {1'b0, tick_cnt} + (PW+1)'(1);
  assign col_lo     = lowest_set(bus.col_alive);
  assign col_hi     = highest_set(bus.col_alive);
  assign left_edge  = {1'b0, form_x} + 12'(int'(col_lo) * PITCH);
  assign right_edge = {1'b0, form_x} + 12'(int'(col_hi) * PITCH + ENEMY_W);
  assign hit_edge   = dir ? (left_edge < 12'(ENEMY_SPEED))
                          : (({1'b0, right_edge} + 13'(ENEMY_SPEED)) > 13'(HRES));
  assign bottom_nxt = {1'b0, form_y} + 11'(DROP) + 11'(FORM_H);
  assign invade     = bottom_nxt > 11'(V_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
    end
  end

  // A tick moves once the count reaches the period; >= covers a period that
  // shrank below the running count when columns died mid-period.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    move         = 1'b0;
    if (bus.start) begin
      state_nxt    = S_MARCH;
      tick_cnt_nxt = '0;
    end else if (state == S_MARCH) begin
      if (bus.col_alive == '0) begin
        state_nxt = S_CLEAR;
      end else if (!bus.pause && bus.frame_tick) begin
        if (cnt_inc >= {1'b0, period}) begin
          move         = 1'b1;
          tick_cnt_nxt = '0;
          if (hit_edge && invade) state_nxt = S_INVADED;
        end else begin
          tick_cnt_nxt = cnt_inc[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    form_x_nxt   = form_x;
    form_y_nxt   = form_y;
    dir_nxt      = dir;
    step_nxt     = 1'b0;
    drop_nxt     = 1'b0;
    invaded_nxt  = invaded;
    clear_nxt    = wave_clear;
    marching_nxt = (state_nxt == S_MARCH);
    if (bus.start) begin
      form_x_nxt  = 11'(HSTART);
      form_y_nxt  = 10'(VSTART);
      dir_nxt     = 1'b0;
      invaded_nxt = 1'b0;
      clear_nxt   = 1'b0;
    end else if (state == S_MARCH && bus.col_alive == '0) begin
      clear_nxt = 1'b1;
    end else if (move) begin
      if (hit_edge) begin
        form_y_nxt = form_y + 10'(DROP);
        dir_nxt    = ~dir;
        drop_nxt   = 1'b1;
        if (invade) invaded_nxt = 1'b1;
      end else begin
        step_nxt   = 1'b1;
        form_x_nxt = dir ? (form_x - 11'(ENEMY_SPEED)) : (form_x + 11'(ENEMY_SPEED));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      form_x     <= 11'(HSTART);
      form_y     <= 10'(VSTART);
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      drop_pulse <= 1'b0;
      marching   <= 1'b0;
      invaded    <= 1'b0;
      wave_clear <= 1'b0;
    end else begin
      form_x     <= form_x_nxt;
      form_y     <= form_y_nxt;
      dir        <= dir_nxt;
      step_pulse <= step_nxt;
      drop_pulse <= drop_nxt;
      marching   <= marching_nxt;
      invaded    <= invaded_nxt;
      wave_clear <= clear_nxt;
    end
  end

  assign bus.form_x     = form_x;
  assign bus.form_y     = form_y;
  assign bus.dir        = dir;
  assign bus.step_pulse = step_pulse;
  assign bus.drop_pulse = drop_pulse;
  assign bus.marching   = marching;
  assign bus.invaded    = invaded;
  assign bus.wave_clear = wave_clear;
endmodule
